// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl: branch predictor table sequencer (sweep init, write-port arbitration, prediction gating).
// Optional statistics counters are built when BP_CTRL_STATS_EN is defined.
module bp_table_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_W      = 8
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  flush_req,
    input  logic                  branch_ex,
    input  logic [ADDR_WIDTH-1:0] branch_pc_ex,
    input  logic                  branch_taken_ex,
    input  logic [ADDR_WIDTH-1:0] branch_target_ex,
    input  logic                  inv_valid,
    input  logic [IDX_W-1:0]      inv_idx,
    output logic                  inv_ready,
    output logic                  tbl_wen,
    output logic [IDX_W-1:0]      tbl_waddr,
    output logic [ADDR_WIDTH-1:0] tbl_wpc,
    output logic [ADDR_WIDTH-1:0] tbl_wtarget,
    output logic                  tbl_wtaken,
    output logic                  tbl_winit,
    output logic                  predict_en,
    output logic                  flush_busy,
    output logic [15:0]           upd_cnt,
    output logic [15:0]           drop_cnt
);
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      sweep_q, sweep_d;
    logic                  hold_v_q, hold_v_d;
    logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d, hold_tgt_q, hold_tgt_d;
    logic                  hold_tk_q, hold_tk_d;
    logic [1:0]            starve_q, starve_d;
    logic                  predict_q, predict_d;
    logic                  wen_q, wen_d, winit_q, winit_d, wtaken_q, wtaken_d;
    logic [IDX_W-1:0]      waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] wpc_q, wpc_d, wtarget_q, wtarget_d;
    logic                  inv_win;

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        hold_v_d   = hold_v_q;
        hold_pc_d  = hold_pc_q;
        hold_tgt_d = hold_tgt_q;
        hold_tk_d  = hold_tk_q;
        starve_d   = starve_q;
        predict_d  = 1'b0;
        wen_d      = 1'b0;
        winit_d    = winit_q;
        wtaken_d   = wtaken_q;
        waddr_d    = waddr_q;
        wpc_d      = wpc_q;
        wtarget_d  = wtarget_q;
        inv_win    = 1'b0;
        if (flush_req) begin
            state_d  = S_INIT;
            sweep_d  = '0;
            hold_v_d = 1'b0;
            starve_d = 2'd0;
        end else if (state_q == S_INIT) begin
            wen_d     = 1'b1;
            winit_d   = 1'b1;
            waddr_d   = sweep_q;
            wpc_d     = '1;
            wtarget_d = '0;
            wtaken_d  = 1'b0;
            sweep_d   = sweep_q + 1'b1;
            state_d   = (&sweep_q) ? S_RUN : S_INIT;
        end else begin
            predict_d = 1'b1;
            // A starved invalidate overrides a live EX update; the update parks in hold.
            inv_win   = !hold_v_q && inv_valid && (starve_q == 2'd3 || !branch_ex);
            if (hold_v_q || inv_win || branch_ex) begin
                wen_d     = 1'b1;
                winit_d   = inv_win;
                waddr_d   = inv_win ? inv_idx : hold_v_q ? hold_pc_q[IDX_W+1:2] : branch_pc_ex[IDX_W+1:2];
                wpc_d     = inv_win ? '1 : hold_v_q ? hold_pc_q : branch_pc_ex;
                wtarget_d = inv_win ? '0 : hold_v_q ? hold_tgt_q : branch_target_ex;
                wtaken_d  = inv_win ? 1'b0 : hold_v_q ? hold_tk_q : branch_taken_ex;
            end
            if (hold_v_q || inv_win) begin
                hold_v_d   = branch_ex;
                hold_pc_d  = branch_ex ? branch_pc_ex : hold_pc_q;
                hold_tgt_d = branch_ex ? branch_target_ex : hold_tgt_q;
                hold_tk_d  = branch_ex ? branch_taken_ex : hold_tk_q;
            end
            starve_d = inv_win ? 2'd0 : (inv_valid && starve_q != 2'd3) ? starve_q + 2'd1 : starve_q;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q    <= S_INIT;
            sweep_q    <= '0;
            hold_v_q   <= 1'b0;
            hold_pc_q  <= '0;
            hold_tgt_q <= '0;
            hold_tk_q  <= 1'b0;
            starve_q   <= 2'd0;
            predict_q  <= 1'b0;
            wen_q      <= 1'b0;
            winit_q    <= 1'b0;
            wtaken_q   <= 1'b0;
            waddr_q    <= '0;
            wpc_q      <= '0;
            wtarget_q  <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            hold_v_q   <= hold_v_d;
            hold_pc_q  <= hold_pc_d;
            hold_tgt_q <= hold_tgt_d;
            hold_tk_q  <= hold_tk_d;
            starve_q   <= starve_d;
            predict_q  <= predict_d;
            wen_q      <= wen_d;
            winit_q    <= winit_d;
            wtaken_q   <= wtaken_d;
            waddr_q    <= waddr_d;
            wpc_q      <= wpc_d;
            wtarget_q  <= wtarget_d;
        end
    end

    assign inv_ready   = inv_win;
    assign tbl_wen     = wen_q;
    assign tbl_winit   = winit_q;
    assign tbl_waddr   = waddr_q;
    assign tbl_wpc     = wpc_q;
    assign tbl_wtarget = wtarget_q;
    assign tbl_wtaken  = wtaken_q;
    assign predict_en  = predict_q;
    assign flush_busy  = !predict_q;

`ifdef BP_CTRL_STATS_EN
    logic [15:0] upd_q, drop_q;
    logic        upd_inc, drop_inc;

    // Hold drains count here too: every non-init write carries an EX update.
    assign upd_inc  = wen_d && !winit_d;
    assign drop_inc = branch_ex && (flush_req || state_q == S_INIT);

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            upd_q  <= '0;
            drop_q <= '0;
        end else begin
            upd_q  <= upd_q + {15'd0, upd_inc && !(&upd_q)};
            drop_q <= drop_q + {15'd0, drop_inc && !(&drop_q)};
        end
    end

    assign upd_cnt  = upd_q;
    assign drop_cnt = drop_q;
`else
    assign upd_cnt  = '0;
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_bp_table_ctrl.sv
// tb_bp_table_ctrl: directed self-checking bench for bp_table_ctrl.
module tb_bp_table_ctrl;
    logic        cpu_clk = 1'b0, cpu_rstn = 1'b0, flush_req = 1'b0;
    logic        branch_ex = 1'b0, branch_taken_ex = 1'b0, inv_valid = 1'b0;
    logic [31:0] branch_pc_ex = '0, branch_target_ex = '0;
    logic [7:0]  inv_idx = '0;
    logic        inv_ready, tbl_wen, tbl_wtaken, tbl_winit, predict_en, flush_busy;
    logic [7:0]  tbl_waddr;
    logic [31:0] tbl_wpc, tbl_wtarget;
    logic [15:0] upd_cnt, drop_cnt;
    logic [74:0] obs_w, prev_w;
    int          checks = 0, failures = 0, n_upd = 0, n_drop = 0;
`ifdef BP_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    bp_table_ctrl #(.ADDR_WIDTH(32), .IDX_W(8)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .flush_req(flush_req),
        .branch_ex(branch_ex), .branch_pc_ex(branch_pc_ex), .branch_taken_ex(branch_taken_ex),
        .branch_target_ex(branch_target_ex), .inv_valid(inv_valid), .inv_idx(inv_idx),
        .inv_ready(inv_ready), .tbl_wen(tbl_wen), .tbl_waddr(tbl_waddr), .tbl_wpc(tbl_wpc),
        .tbl_wtarget(tbl_wtarget), .tbl_wtaken(tbl_wtaken), .tbl_winit(tbl_winit),
        .predict_en(predict_en), .flush_busy(flush_busy), .upd_cnt(upd_cnt), .drop_cnt(drop_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;
    assign obs_w = {tbl_wen, tbl_winit, tbl_waddr, tbl_wpc, tbl_wtarget, tbl_wtaken};

    function automatic logic [74:0] init_w(input logic [7:0] idx);
        return {1'b1, 1'b1, idx, 32'hFFFF_FFFF, 32'h0, 1'b0};
    endfunction

    function automatic logic [74:0] ex_w(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        return {1'b1, 1'b0, pc[9:2], pc, tgt, tk};
    endfunction

    function automatic logic [31:0] spc(input int c);
        return 32'h0000_1000 + 32'(c * 4);
    endfunction

    task automatic step;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset;
        cpu_rstn = 1'b0;
        repeat (3) step();
        inv_valid = 1'b1;
        #1;
        checks++;
        if ({obs_w, predict_en, inv_ready, upd_cnt, drop_cnt, flush_busy} !== {75'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset: obs=%h pe=%b ir=%b upd=%0d drop=%0d fb=%b, want all 0 with fb=1",
                     obs_w, predict_en, inv_ready, upd_cnt, drop_cnt, flush_busy);
        end
        inv_valid = 1'b0;
        cpu_rstn  = 1'b1;
    endtask

    task automatic test_sweep(input int drops);
        for (int i = 0; i < 256; i++) begin
            branch_ex = (i < drops);
            step();
            checks++;
            if ({obs_w, predict_en, flush_busy} !== {init_w(8'(i)), 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL sweep[%0d]: obs=%h pe=%b fb=%b, want %h pe=0 fb=1",
                         i, obs_w, predict_en, flush_busy, init_w(8'(i)));
            end
        end
        n_drop += drops;
        branch_ex = 1'b0;
        step();
        checks++;
        if ({tbl_wen, predict_en, flush_busy} !== 3'b010) begin
            failures++;
            $display("FAIL sweep_done: wen=%b pe=%b fb=%b, want wen=0 pe=1 fb=0", tbl_wen, predict_en, flush_busy);
        end
    endtask

    task automatic test_ex_update;
        logic [31:0] pcs [2];
        logic [31:0] tgts [2];
        logic        tks [2];
        pcs[0] = 32'h0000_0104; tgts[0] = 32'h0000_0200; tks[0] = 1'b1;
        pcs[1] = 32'h0000_2008; tgts[1] = 32'h0000_3000; tks[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            branch_ex = 1'b1; branch_pc_ex = pcs[k]; branch_target_ex = tgts[k]; branch_taken_ex = tks[k];
            step();
            branch_ex = 1'b0;
            n_upd++;
            checks++;
            if (obs_w !== ex_w(pcs[k], tgts[k], tks[k])) begin
                failures++;
                $display("FAIL ex_update[%0d]: obs=%h want=%h", k, obs_w, ex_w(pcs[k], tgts[k], tks[k]));
            end
        end
        checks++;
        if (tbl_waddr !== 8'h02) begin
            failures++;
            $display("FAIL ex_index: waddr=%h want 02", tbl_waddr);
        end
        prev_w = obs_w;
        step();
        checks++;
        if (obs_w !== {1'b0, prev_w[73:0]}) begin
            failures++;
            $display("FAIL idle_hold: obs=%h want=%h", obs_w, {1'b0, prev_w[73:0]});
        end
        checks++;
        if ({upd_cnt, drop_cnt} !== {(STATS ? 16'(n_upd) : 16'd0), (STATS ? 16'(n_drop) : 16'd0)}) begin
            failures++;
            $display("FAIL stats_run: upd=%0d drop=%0d want upd=%0d drop=%0d",
                     upd_cnt, drop_cnt, STATS ? n_upd : 0, STATS ? n_drop : 0);
        end
    endtask

    task automatic test_inv_plain;
        inv_valid = 1'b1; inv_idx = 8'd7;
        #1;
        checks++;
        if (inv_ready !== 1'b1) begin
            failures++;
            $display("FAIL inv_plain_ready: inv_ready=%b want 1", inv_ready);
        end
        step();
        inv_valid = 1'b0;
        checks++;
        if (obs_w !== init_w(8'd7)) begin
            failures++;
            $display("FAIL inv_plain_write: obs=%h want=%h", obs_w, init_w(8'd7));
        end
    endtask

    task automatic test_starvation;
        logic        exp_ready;
        logic [74:0] exp_w;
        for (int c = 1; c <= 9; c++) begin
            branch_ex        = (c <= 6);
            branch_pc_ex     = spc(c);
            branch_target_ex = 32'h0000_8000 + 32'(c);
            branch_taken_ex  = c[0];
            inv_valid        = (c <= 4) || (c >= 5 && c <= 8);
            inv_idx          = (c <= 4) ? 8'd5 : 8'd9;
            #1;
            exp_ready = (c == 4) || (c == 8);
            checks++;
            if (inv_ready !== exp_ready) begin
                failures++;
                $display("FAIL starve_ready[c=%0d]: inv_ready=%b want %b", c, inv_ready, exp_ready);
            end
            prev_w = obs_w;
            step();
            if (c <= 3) exp_w = ex_w(spc(c), 32'h0000_8000 + 32'(c), c[0]);
            else if (c == 4) exp_w = init_w(8'd5);
            else if (c <= 7) exp_w = ex_w(spc(c - 1), 32'h0000_8000 + 32'(c - 1), (c - 1) % 2 == 1);
            else if (c == 8) exp_w = init_w(8'd9);
            else exp_w = {1'b0, prev_w[73:0]};
            if (c <= 3 || (c >= 5 && c <= 7)) n_upd++;
            checks++;
            if (obs_w !== exp_w) begin
                failures++;
                $display("FAIL starve_write[c=%0d]: obs=%h want=%h", c, obs_w, exp_w);
            end
        end
        branch_ex = 1'b0; inv_valid = 1'b0;
        checks++;
        if (upd_cnt !== (STATS ? 16'(n_upd) : 16'd0)) begin
            failures++;
            $display("FAIL stats_starve: upd=%0d want %0d", upd_cnt, STATS ? n_upd : 0);
        end
    endtask

    task automatic test_flush;
        flush_req = 1'b1; branch_ex = 1'b1; branch_pc_ex = 32'h0000_0400; inv_valid = 1'b1; inv_idx = 8'd3;
        #1;
        checks++;
        if (inv_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_inv_ready: inv_ready=%b want 0", inv_ready);
        end
        step();
        flush_req = 1'b0; branch_ex = 1'b0; inv_valid = 1'b0;
        n_drop++;
        checks++;
        if ({tbl_wen, predict_en, flush_busy} !== 3'b001) begin
            failures++;
            $display("FAIL flush_enter: wen=%b pe=%b fb=%b want wen=0 pe=0 fb=1", tbl_wen, predict_en, flush_busy);
        end
        for (int i = 0; i < 100; i++) step();
        checks++;
        if (obs_w !== init_w(8'd99)) begin
            failures++;
            $display("FAIL flush_mid: obs=%h want=%h", obs_w, init_w(8'd99));
        end
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        checks++;
        if ({tbl_wen, predict_en} !== 2'b00) begin
            failures++;
            $display("FAIL flush_restart: wen=%b pe=%b want 0 0", tbl_wen, predict_en);
        end
        test_sweep(0);
        checks++;
        if (drop_cnt !== (STATS ? 16'(n_drop) : 16'd0)) begin
            failures++;
            $display("FAIL stats_flush: drop=%0d want %0d", drop_cnt, STATS ? n_drop : 0);
        end
    endtask

    task automatic test_async_reset;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        branch_ex = 1'b1;
        repeat (5) step();
        branch_ex = 1'b0;
        #2;
        cpu_rstn = 1'b0;
        #1;
        checks++;
        if ({obs_w, predict_en, flush_busy, upd_cnt, drop_cnt} !== {75'd0, 1'b0, 1'b1, 16'd0, 16'd0}) begin
            failures++;
            $display("FAIL async_reset: obs=%h pe=%b fb=%b upd=%0d drop=%0d want zeros fb=1",
                     obs_w, predict_en, flush_busy, upd_cnt, drop_cnt);
        end
        step();
        cpu_rstn = 1'b1;
        step();
        checks++;
        if (obs_w !== init_w(8'd0)) begin
            failures++;
            $display("FAIL async_restart: obs=%h want=%h", obs_w, init_w(8'd0));
        end
    endtask

    initial begin
        test_reset();
        test_sweep(3);
        test_ex_update();
        test_inv_plain();
        test_starvation();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
